mem_access_ctrl: RTL and testbench

Sequencer between the CPU's MEM stage and the word-wide data memory. It accepts one load/store request at a time and drives a single memory access with byte enables. Loads return the selected byte or halfword sign- or zero-extended to 32 bits, and stores are lane-replicated. The block also detects misaligned or illegal-size accesses and memory timeouts, and reports them instead of completing the access.

---
 rtl/mem_access_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store from the MEM stage into a single
// word-wide memory access with byte enables, load extension, misalignment
// detection and an optional wait-state timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic               we_q, we_d;
  logic               mem_en_q, mem_en_d;
  logic [3:0]         mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [1:0]         resp_err_q, resp_err_d;

  logic               misaligned;
  logic [3:0]         byte_en;
  logic [31:0]        lane_wdata;
  logic [31:0]        lane_rdata;
  logic [31:0]        load_ext;

  // Request decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    byte_en    = 4'b1111;
    lane_wdata = req_wdata;
    misaligned = 1'b0;
    case (req_size)
      2'b00: begin
        byte_en    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = 4'b0011 << req_addr[1:0];
        lane_wdata = {2{req_wdata[15:0]}};
        misaligned = req_addr[0];
      end
      2'b10: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Load path: pick the addressed lane of the read word and extend it.
  always_comb begin
    lane_rdata = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, lane_rdata[7:0]}
                                : {{24{lane_rdata[7]}}, lane_rdata[7:0]};
      2'b01:   load_ext = uns_q ? {16'd0, lane_rdata[15:0]}
                                : {{16{lane_rdata[15]}}, lane_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          we_d   = req_we;
          if (misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 2'b01;
            resp_rdata_d = 32'd0;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we ? byte_en : 4'b0000;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = lane_wdata;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d      = RESP;
          mem_en_d     = 1'b0;
          mem_we_d     = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 2'b00;
          resp_rdata_d = we_q ? 32'd0 : load_ext;
        end else if (TIMEOUT != 0 && cnt_q == CNT_MAX) begin
          state_d      = RESP;
          mem_en_d     = 1'b0;
          mem_we_d     = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 2'b10;
          resp_rdata_d = 32'd0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset forces IDLE and clears every output at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 4'b0000;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed test-plan cases, boundary cases and
// randomized requests checked against a behavioural model of the access rules.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Access rules in arithmetic form: access width in bytes, alignment as a modulus,
  // byte lanes as a shifted mask, store data by repeating the low bytes.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rword,
                                output logic [1:0] err, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] rd);
    int unsigned nb, off;
    logic [31:0] val, mask;
    off = addr % 4;
    nb  = 1 << size;
    err = 2'b00;
    be  = 4'b0000;
    wd  = 32'd0;
    rd  = 32'd0;
    if (size == 2'd3 || (addr % nb) != 0) err = 2'b01;
    if (err == 2'b00) begin
      if (we) be = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      val  = (rword >> (8 * off)) & mask;
      if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
      if (!we) rd = val;
    end
  endfunction

  // One request from accept to the cycle after its response; memory answers
  // after 'delay' wait cycles (or never, if that exceeds the timeout).
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input int delay,
                           output logic [31:0] got_rdata, output logic [1:0] got_err,
                           output logic [3:0] got_we);
    logic [1:0]  e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    int          edges, exp_edges;
    bit          done;
    model(we, size, uns, addr, wdata, rword, e_err, e_be, e_wd, e_rd);
    edges = 0;
    while (!req_ready && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    check("req_ready", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom);
    got_we    = mem_we;
    if (e_err[0]) begin
      check("err_resp_valid", 32'(resp_valid), 32'd1);
      check("err_mem_en", 32'(mem_en), 32'd0);
      check("err_mem_we", 32'(mem_we), 32'd0);
      check("err_code", 32'(resp_err), 32'(e_err));
      check("err_rdata", resp_rdata, 32'd0);
    end else begin
      check("acc_mem_en", 32'(mem_en), 32'd1);
      check("acc_mem_we", 32'(mem_we), 32'(e_be));
      check("acc_mem_addr", mem_addr, addr & ~32'd3);
      if (we) check("acc_mem_wdata", mem_wdata, e_wd);
      mem_ready = (delay == 0);
      mem_rdata = (delay == 0) ? rword : $urandom;
      edges = 0;
      done  = 1'b0;
      while (!done && edges < 40) begin
        @(posedge clk); #1;
        edges++;
        if (resp_valid) done = 1'b1;
        else begin
          check("hold_mem_en", 32'(mem_en), 32'd1);
          check("hold_mem_we", 32'(mem_we), 32'(e_be));
          check("hold_mem_addr", mem_addr, addr & ~32'd3);
          if (we) check("hold_mem_wdata", mem_wdata, e_wd);
          mem_ready = (edges == delay);
          mem_rdata = (edges == delay) ? rword : $urandom;
        end
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (delay > TO) begin
        exp_edges = TO + 1;
        e_err     = 2'b10;
        e_rd      = 32'd0;
      end else exp_edges = delay + 1;
      check("resp_seen", 32'(done), 32'd1);
      check("resp_latency", 32'(edges), 32'(exp_edges));
      check("resp_mem_en", 32'(mem_en), 32'd0);
      check("resp_mem_we", 32'(mem_we), 32'd0);
      check("resp_err", 32'(resp_err), 32'(e_err));
      check("resp_rdata", resp_rdata, e_rd);
    end
    got_rdata = resp_rdata;
    got_err   = resp_err;
    @(posedge clk); #1;
    check("resp_pulse_end", 32'(resp_valid), 32'd0);
    check("resp_rdata_hold", resp_rdata, e_rd);
    check("resp_err_hold", 32'(resp_err), 32'(e_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  er;
    logic [3:0]  wev;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    int          r_delay;
    bit          saw_resp;

    // Reset state
    #1;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Byte loads, signed and unsigned
    do_access(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'h80FF7F01, 0, rd, er, wev);
    check("lb_value", rd, 32'hFFFFFF80);
    do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'h80FF7F01, 0, rd, er, wev);
    check("lbu_value", rd, 32'h00000080);

    // Halfword loads
    do_access(1'b0, 2'b01, 1'b0, 32'h2, 32'd0, 32'h8001ABCD, 0, rd, er, wev);
    check("lh_value", rd, 32'hFFFF8001);
    do_access(1'b0, 2'b01, 1'b1, 32'h0, 32'd0, 32'h8001ABCD, 1, rd, er, wev);
    check("lhu_value", rd, 32'h0000ABCD);

    // Stores
    do_access(1'b1, 2'b00, 1'b0, 32'h6, 32'h000000A5, 32'hDEADBEEF, 0, rd, er, wev);
    check("sb_we", 32'(wev), 32'b0100);
    check("sb_rdata", rd, 32'd0);
    do_access(1'b1, 2'b01, 1'b0, 32'h2, 32'h12345678, 32'hDEADBEEF, 2, rd, er, wev);
    check("sh_we", 32'(wev), 32'b1100);
    do_access(1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D, 32'hDEADBEEF, 0, rd, er, wev);
    check("sw_we", 32'(wev), 32'b1111);

    // Misaligned and illegal-size requests
    do_access(1'b0, 2'b10, 1'b0, 32'h6, 32'd0, 32'h11111111, 0, rd, er, wev);
    check("lw_mis_err", 32'(er), 32'b01);
    do_access(1'b0, 2'b01, 1'b0, 32'h1, 32'd0, 32'h11111111, 0, rd, er, wev);
    check("lh_mis_err", 32'(er), 32'b01);
    do_access(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h11111111, 0, rd, er, wev);
    check("size11_err", 32'(er), 32'b01);

    // Wait states, ready exactly at the limit, and timeouts
    do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'h5A5A1234, 3, rd, er, wev);
    check("wait3_value", rd, 32'h5A5A1234);
    do_access(1'b0, 2'b00, 1'b1, 32'h41, 32'd0, 32'h0000C300, TO, rd, er, wev);
    check("ready_at_limit", 32'(er), 32'b00);
    do_access(1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 32'h77777777, TO + 1, rd, er, wev);
    check("timeout_err", 32'(er), 32'b10);
    do_access(1'b1, 2'b10, 1'b0, 32'h48, 32'h01020304, 32'h0, 20, rd, er, wev);
    check("timeout_store_err", 32'(er), 32'b10);

    // mem_ready while idle does nothing
    mem_ready = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    mem_ready = 1'b0;
    check("idle_ready_no_resp", 32'(saw_resp), 32'd0);
    check("idle_ready_no_en", 32'(mem_en), 32'd0);

    // Reset during an access
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h20;
    req_wdata = 32'h89ABCDEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_rst_en_before", 32'(mem_en), 32'd1);
    check("mid_rst_we_before", 32'(mem_we), 32'b1111);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_en_async", 32'(mem_en), 32'd0);
    check("mid_rst_we_async", 32'(mem_we), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    saw_resp = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    check("mid_rst_no_resp", 32'(saw_resp), 32'd0);
    do_access(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 32'hF00D0042, 1, rd, er, wev);
    check("after_rst_value", rd, 32'hFFFFF00D);

    // Randomized requests against the model
    for (int n = 0; n < 40; n++) begin
      r_we    = 1'($urandom);
      r_size  = 2'($urandom_range(0, 3));
      r_uns   = 1'($urandom);
      r_delay = $urandom_range(0, TO + 2);
      do_access(r_we, r_size, r_uns, $urandom, $urandom, $urandom, r_delay, rd, er, wev);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
